// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM encoding (IDLE / REQ / SKID / DISCARD)
//   RESET_PC_DEF  : default PC loaded on reset
//   PC_INC_DEF    : default PC increment per fetched instruction
//   NOP_WORD      : word used for bubbles and cleared buffers
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SKID    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'd0;
    localparam logic [31:0] PC_INC_DEF   = 32'd4;
    localparam logic [31:0] NOP_WORD     = 32'd0;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and the memory.
//   mem_req   : read request, driven by the fetch unit (master)
//   mem_addr  : read address, stable while mem_req=1 and mem_ack=0
//   mem_ack   : one-cycle completion pulse, driven by the memory (slave)
//   mem_rdata : read data, valid in the cycle mem_ack=1
// Handshake: a transaction is open from the cycle mem_req is seen high until
// the cycle mem_ack is high; the memory samples mem_addr while mem_req=1 and
// the fetch unit samples mem_rdata only on the rising edge where mem_ack=1.
interface if_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry {pc, instruction} holding register for a memory response that
// arrives while the IF/ID output is frozen.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture pc_i / instr_i and mark the entry valid
//   clear_i    : empty the entry (wins over load_i)
//   pc_i       : pc value to hold (already incremented)
//   instr_i    : instruction word to hold
//   valid_o    : entry holds a live response
//   pc_o       : held pc
//   instr_o    : held instruction
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= NOP_WORD;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= NOP_WORD;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch engine feeding the IF/ID pipeline register. Owns the
// architectural PC, issues one word read at a time on the instruction-memory
// bus, handles branch redirects and presents {pc+PC_INC, instruction, valid}
// to IF/ID, which consumes the output whenever freeze is low.
//   clk, rst_n   : clock, asynchronous active-low reset (memory shares rst_n)
//   freeze       : downstream stall, output held while high
//   branch_taken : one-cycle redirect request, highest priority
//   branch_addr  : redirect target
//   imem         : instruction-memory bus (master side)
//   pc           : address of buffered instruction + PC_INC
//   instruction  : buffered instruction word
//   out_valid    : pc/instruction hold a live fetch
//   state_o      : current FSM state, for observation
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_addr,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc,
    output logic [31:0]            instruction,
    output logic                   out_valid,
    output fetch_state_e           state_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_reg_q;
    logic         mem_req_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  out_pc_q;
    logic [31:0]  out_instr_q;
    logic         out_valid_q;

    logic         consume;
    logic         buf_free;
    logic [31:0]  pc_next;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    // IF/ID takes the current output on this edge; the output register can
    // accept a new word if it is empty or being drained right now.
    assign consume  = out_valid_q & ~freeze;
    assign buf_free = ~out_valid_q | consume;
    assign pc_next  = pc_reg_q + PC_INC;

    // A response that lands while the output is blocked goes to the skid
    // entry; the entry empties on a redirect or when it moves to the output.
    always_comb begin
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (branch_taken) begin
            skid_clear = 1'b1;
        end else if (state_q == ST_REQ && imem.mem_ack && !buf_free) begin
            skid_load = 1'b1;
        end else if (state_q == ST_SKID && consume) begin
            skid_clear = 1'b1;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_next),
        .instr_i (imem.mem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_reg_q    <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            out_pc_q    <= 32'd0;
            out_instr_q <= NOP_WORD;
            out_valid_q <= 1'b0;
        end else if (branch_taken) begin
            // Redirect: bubble the output and restart at the target. An
            // in-flight read that has not completed still owns the bus, so
            // its address is held and its response is discarded later.
            pc_reg_q    <= branch_addr;
            out_pc_q    <= 32'd0;
            out_instr_q <= NOP_WORD;
            out_valid_q <= 1'b0;
            mem_req_q   <= 1'b1;
            if ((state_q == ST_REQ && !imem.mem_ack) || state_q == ST_DISCARD) begin
                state_q <= ST_DISCARD;
            end else begin
                state_q    <= ST_REQ;
                mem_addr_q <= branch_addr;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_REQ;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= pc_reg_q;
                end
                ST_REQ: begin
                    if (imem.mem_ack) begin
                        pc_reg_q   <= pc_next;
                        mem_addr_q <= pc_next;
                        if (buf_free) begin
                            out_pc_q    <= pc_next;
                            out_instr_q <= imem.mem_rdata;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_SKID;
                            mem_req_q <= 1'b0;
                        end
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (consume && skid_valid) begin
                        out_pc_q    <= skid_pc;
                        out_instr_q <= skid_instr;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= pc_reg_q;
                    end
                end
                ST_DISCARD: begin
                    if (consume) begin
                        out_valid_q <= 1'b0;
                    end
                    if (imem.mem_ack) begin
                        state_q    <= ST_REQ;
                        mem_addr_q <= pc_reg_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.mem_req  = mem_req_q;
    assign imem.mem_addr = mem_addr_q;
    assign pc            = out_pc_q;
    assign instruction   = out_instr_q;
    assign out_valid     = out_valid_q;
    assign state_o       = state_q;

endmodule
